// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore keeper: controller state and index sizing.
package hiscore_pkg;

  typedef enum logic [1:0] {
    WAIT_SIG = 2'd0,
    RESTORE  = 2'd1,
    RUN      = 2'd2
  } hs_state_e;

  // Buffer index width; a one-entry region still needs one address bit.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/hiscore_buffer.sv
// True dual-port hiscore image RAM, read-first, registered read on both ports.
module hiscore_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 114,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; the image survives a game reset.
  always_ff @(posedge clk) begin
    if (a_we && (int'(a_addr) < DEPTH)) mem[a_addr] <= a_wdata;
    if (b_we && (int'(b_addr) < DEPTH)) mem[b_addr] <= b_wdata;
  end

  // Read registers sample the pre-write contents (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/hiscore_keeper.sv
// Signature-armed hiscore restore into side RAM by stealing idle bus cycles,
// then mirroring game writes to the region for host readback.
module hiscore_keeper
  import hiscore_pkg::*;
#(
  parameter int                ADDR_W      = 11,
  parameter int                DATA_W      = 8,
  parameter int                NUM_TESTS   = 5,
  parameter logic [ADDR_W-1:0] TEST_ADDR [NUM_TESTS] = '{11'h650, 11'h651, 11'h6bf, 11'h6c0, 11'h6c1},
  parameter logic [DATA_W-1:0] TEST_DATA [NUM_TESTS] = '{8'heb, 8'hf8, 8'h30, 8'h30, 8'hff},
  parameter logic [ADDR_W-1:0] REGION_BASE = 11'h650,
  parameter int                REGION_LEN  = 'h72,
  parameter int                IDX_W       = idx_width(REGION_LEN)
) (
  input  logic              game_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_data,
  input  logic              mon_nCS,
  input  logic              mon_nWE,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_nCS,
  output logic              out_nWE,
  input  logic              ld_wr,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              armed,
  output logic              restoring,
  output logic              dirty,
  input  logic              dirty_clr
);

  // One extra bit on the end bound so a region touching the top of RAM cannot wrap.
  localparam logic [ADDR_W:0]  REGION_END = {1'b0, REGION_BASE} + (ADDR_W+1)'(REGION_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(REGION_LEN - 1);

  hs_state_e            state;
  hs_state_e            state_nxt;
  logic [NUM_TESTS-1:0] test_hit;
  logic                 armed_r;
  logic                 loaded;
  logic                 primed;
  logic                 dirty_r;
  logic [IDX_W-1:0]     idx;

  logic                 game_wr;
  logic                 in_region;
  logic                 inject;
  logic                 mirror_wr;
  logic                 buf_ld_wr;
  logic [IDX_W-1:0]     mon_idx;
  logic [IDX_W-1:0]     port_a_addr;
  logic [IDX_W-1:0]     port_b_addr;
  logic [DATA_W-1:0]    restore_data;

  assign game_wr   = ~mon_nCS & ~mon_nWE;
  assign in_region = ({1'b0, mon_addr} >= {1'b0, REGION_BASE}) &&
                     ({1'b0, mon_addr} <  REGION_END);
  assign mon_idx   = IDX_W'(mon_addr - REGION_BASE);

  // A stolen cycle needs a primed byte and a bus the game left idle.
  assign inject    = (state == RESTORE) & primed & mon_nCS;
  assign mirror_wr = (state == RUN) & game_wr & in_region;
  assign buf_ld_wr = (state == WAIT_SIG) & ld_wr;

  assign port_a_addr = buf_ld_wr ? ld_addr : rd_addr;
  assign port_b_addr = (state == RUN) ? mon_idx : idx;

  hiscore_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (REGION_LEN),
    .AW     (IDX_W)
  ) u_buffer (
    .clk     (game_clk),
    .rst_n   (reset_n),
    .a_we    (buf_ld_wr),
    .a_addr  (port_a_addr),
    .a_wdata (ld_data),
    .a_rdata (rd_data),
    .b_we    (mirror_wr),
    .b_addr  (port_b_addr),
    .b_wdata (mon_data),
    .b_rdata (restore_data)
  );

  always_comb begin
    out_addr = mon_addr;
    out_data = mon_data;
    out_nCS  = mon_nCS;
    out_nWE  = mon_nWE;
    if (inject) begin
      out_addr = REGION_BASE + ADDR_W'(idx);
      out_data = restore_data;
      out_nCS  = 1'b0;
      out_nWE  = 1'b0;
    end
  end

  // Signature detection: sticky per-test hits, armed registered one edge later.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      test_hit <= '0;
      armed_r  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TESTS; i++) begin
        if (game_wr && (mon_addr == TEST_ADDR[i]) && (mon_data == TEST_DATA[i]))
          test_hit[i] <= 1'b1;
      end
      armed_r <= &test_hit;
    end
  end

  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded <= 1'b0;
    end else if ((state == WAIT_SIG) && ld_done) begin
      loaded <= 1'b1;
    end
  end

  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_SIG;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_SIG: if (armed_r) state_nxt = loaded ? RESTORE : RUN;
      RESTORE:  if (inject && (idx == LAST_IDX)) state_nxt = RUN;
      RUN:      state_nxt = RUN;
      default:  state_nxt = WAIT_SIG;
    endcase
  end

  // Restore engine: a non-primed cycle issues the read of idx, a primed idle cycle injects it.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      primed <= 1'b0;
    end else if (state == RESTORE) begin
      if (inject) begin
        idx    <= idx + 1'b1;
        primed <= 1'b0;
      end else begin
        primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n)       dirty_r <= 1'b0;
    else if (mirror_wr) dirty_r <= 1'b1;
    else if (dirty_clr) dirty_r <= 1'b0;
  end

  assign armed     = armed_r;
  assign restoring = (state == RESTORE);
  assign dirty     = dirty_r;

endmodule

// File: tb/tb_hiscore_keeper.sv
// Self-checking bench for hiscore_keeper: signature table, restore streams,
// mirror/dirty corners, mid-restore reset and a randomized RUN phase.
module tb_hiscore_keeper;

  localparam int          REGION_LEN = 'h72;
  localparam logic [10:0] BASE       = 11'h650;

  logic        game_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [10:0] mon_addr;
  logic [7:0]  mon_data;
  logic        mon_nCS, mon_nWE;
  logic [10:0] out_addr;
  logic [7:0]  out_data;
  logic        out_nCS, out_nWE;
  logic        ld_wr, ld_done, dirty_clr;
  logic [6:0]  ld_addr, rd_addr;
  logic [7:0]  ld_data, rd_data;
  logic        armed, restoring, dirty;

  int checks = 0;
  int errors = 0;

  logic [10:0] sig_addr [5] = '{11'h650, 11'h651, 11'h6bf, 11'h6c0, 11'h6c1};
  logic [7:0]  sig_data [5] = '{8'heb, 8'hf8, 8'h30, 8'h30, 8'hff};

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    logic        nwe;
    logic        exp_early;
    logic        exp_late;
  } sig_vec_t;

  sig_vec_t   vecs [8];
  logic [7:0] model_buf [REGION_LEN];
  logic       mdirty;

  hiscore_keeper dut (
    .game_clk  (game_clk),
    .reset_n   (reset_n),
    .mon_addr  (mon_addr),
    .mon_data  (mon_data),
    .mon_nCS   (mon_nCS),
    .mon_nWE   (mon_nWE),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_nCS   (out_nCS),
    .out_nWE   (out_nWE),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_done   (ld_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .armed     (armed),
    .restoring (restoring),
    .dirty     (dirty),
    .dirty_clr (dirty_clr)
  );

  always #5 game_clk = ~game_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pass(input string name);
    checks++;
    if ({out_addr, out_data, out_nCS, out_nWE} !== {mon_addr, mon_data, mon_nCS, mon_nWE}) begin
      errors++;
      $display("FAIL %s: out=%h/%h/%b/%b expected mon=%h/%h/%b/%b", name,
               out_addr, out_data, out_nCS, out_nWE, mon_addr, mon_data, mon_nCS, mon_nWE);
    end
  endtask

  task automatic idle_bus();
    mon_nCS  = 1'b1;
    mon_nWE  = 1'b1;
    mon_addr = 11'h123;
    mon_data = 8'h00;
  endtask

  task automatic step();
    @(posedge game_clk);
    #1;
  endtask

  task automatic game_write(input logic [10:0] a, input logic [7:0] d);
    mon_addr = a;
    mon_data = d;
    mon_nCS  = 1'b0;
    mon_nWE  = 1'b0;
    step();
    idle_bus();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    idle_bus();
    ld_wr     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_done   = 1'b0;
    rd_addr   = '0;
    dirty_clr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic load_image();
    for (int i = 0; i < REGION_LEN; i++) begin
      ld_wr   = 1'b1;
      ld_addr = 7'(i);
      ld_data = 8'(8'h10 + i);
      step();
    end
    ld_wr   = 1'b0;
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
  endtask

  // Feeds all signatures and waits until the controller has had time to leave WAIT_SIG.
  task automatic feed_sigs();
    for (int i = 0; i < 5; i++) game_write(sig_addr[i], sig_data[i]);
    step();
    step();
  endtask

  // Watches the bus while restoring; every stolen write must be the next image byte.
  task automatic run_restore(input bit alt, input int stop_at, output int injects, output int rcycles);
    int exp_i;
    exp_i   = 0;
    injects = 0;
    rcycles = 0;
    for (int n = 0; n < 2000; n++) begin
      if (injects == stop_at) return;
      if (alt && (n % 2 == 1)) begin
        mon_nCS  = 1'b0;
        mon_nWE  = 1'b1;
        mon_addr = 11'($urandom);
        mon_data = 8'($urandom);
      end else begin
        idle_bus();
      end
      #1;
      if (!restoring) break;
      rcycles++;
      if (mon_nCS == 1'b0 || out_nCS == 1'b1) begin
        chk_pass("restore_passthru");
      end else begin
        injects++;
        chk("inj_addr", 32'(out_addr), 32'(BASE) + exp_i);
        chk("inj_data", 32'(out_data), 32'h10 + exp_i);
        chk("inj_nwe", 32'(out_nWE), 0);
        exp_i++;
      end
      step();
    end
    idle_bus();
  endtask

  initial begin
    int inj, rc;
    logic [10:0] a;
    logic [7:0]  d;
    logic        ncs, nwe, clr, wr;
    logic [7:0]  exp_rd;

    vecs[0] = '{11'h650, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{11'h6c1, 8'hff, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{11'h6c0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{11'h6bf, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{11'h651, 8'hf8, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{11'h650, 8'heb, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{11'h650, 8'heb, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{11'h7ff, 8'h00, 1'b0, 1'b1, 1'b1};

    reset_n   = 1'b0;
    ld_wr     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_done   = 1'b0;
    rd_addr   = '0;
    dirty_clr = 1'b0;
    mon_addr  = 11'h2a5;
    mon_data  = 8'h3c;
    mon_nCS   = 1'b0;
    mon_nWE   = 1'b0;
    step();
    chk("rst_armed", 32'(armed), 0);
    chk("rst_restoring", 32'(restoring), 0);
    chk("rst_dirty", 32'(dirty), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk_pass("rst_passthru");
    do_reset();

    // Signatures in reverse order with decoys, no image loaded.
    for (int i = 0; i < 8; i++) begin
      mon_addr = vecs[i].addr;
      mon_data = vecs[i].data;
      mon_nCS  = 1'b0;
      mon_nWE  = vecs[i].nwe;
      #1;
      chk_pass("sig_passthru");
      step();
      idle_bus();
      chk("armed_early", 32'(armed), 32'(vecs[i].exp_early));
      step();
      chk("armed_late", 32'(armed), 32'(vecs[i].exp_late));
    end
    for (int i = 0; i < 6; i++) begin
      chk("norestore_restoring", 32'(restoring), 0);
      chk_pass("norestore_passthru");
      step();
    end
    chk("run_dirty_init", 32'(dirty), 0);

    game_write(11'h660, 8'h55);
    rd_addr = 7'h10;
    step();
    chk("mirror_rd", 32'(rd_data), 32'h55);
    chk("mirror_dirty", 32'(dirty), 1);
    dirty_clr = 1'b1;
    step();
    dirty_clr = 1'b0;
    chk("clr_alone", 32'(dirty), 0);
    game_write(11'h6c2, 8'haa);
    chk("above_region_dirty", 32'(dirty), 0);
    game_write(11'h64f, 8'haa);
    chk("below_region_dirty", 32'(dirty), 0);
    mon_addr  = 11'h6c1;
    mon_data  = 8'h9d;
    mon_nCS   = 1'b0;
    mon_nWE   = 1'b0;
    dirty_clr = 1'b1;
    step();
    dirty_clr = 1'b0;
    idle_bus();
    chk("set_wins_dirty", 32'(dirty), 1);
    rd_addr = 7'h71;
    step();
    chk("last_byte_rd", 32'(rd_data), 32'h9d);
    game_write(11'h650, 8'h11);
    mon_addr = 11'h650;
    mon_data = 8'h22;
    mon_nCS  = 1'b0;
    mon_nWE  = 1'b0;
    rd_addr  = 7'h00;
    step();
    idle_bus();
    chk("read_first_old", 32'(rd_data), 32'h11);
    step();
    chk("read_first_new", 32'(rd_data), 32'h22);

    // Randomized RUN phase against an array model of the region.
    for (int i = 0; i < REGION_LEN; i++) begin
      model_buf[i] = 8'($urandom);
      game_write(BASE + 11'(i), model_buf[i]);
    end
    mdirty = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) a = 11'($urandom);
      else a = BASE - 11'd8 + 11'($urandom_range(0, REGION_LEN + 15));
      d   = 8'($urandom);
      ncs = ($urandom_range(0, 3) == 0);
      nwe = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 5) == 0);
      mon_addr  = a;
      mon_data  = d;
      mon_nCS   = ncs;
      mon_nWE   = nwe;
      dirty_clr = clr;
      rd_addr   = 7'($urandom_range(0, REGION_LEN - 1));
      #1;
      chk_pass("run_passthru");
      exp_rd = model_buf[rd_addr];
      wr = !ncs && !nwe && (a >= BASE) && (a < BASE + 11'(REGION_LEN));
      if (wr) begin
        model_buf[a - BASE] = d;
        mdirty = 1'b1;
      end else if (clr) begin
        mdirty = 1'b0;
      end
      step();
      chk("rand_rd_data", 32'(rd_data), 32'(exp_rd));
      chk("rand_dirty", 32'(dirty), 32'(mdirty));
    end
    dirty_clr = 1'b0;
    idle_bus();

    // Full restore on an idle bus.
    do_reset();
    load_image();
    feed_sigs();
    run_restore(1'b0, -1, inj, rc);
    chk("idle_injects", inj, REGION_LEN);
    chk("idle_restore_cycles", rc, 228);
    chk("idle_after_restoring", 32'(restoring), 0);
    for (int k = 0; k < REGION_LEN; k += 37) begin
      rd_addr = 7'(k);
      step();
      chk("restored_readback", 32'(rd_data), 32'h10 + k);
    end

    // Restore sharing the bus with game reads on alternate cycles.
    do_reset();
    load_image();
    feed_sigs();
    run_restore(1'b1, -1, inj, rc);
    chk("alt_injects", inj, REGION_LEN);
    chk("alt_cycles_ge_idle", 32'(rc >= 228), 1);

    // Reset in the middle of a restore.
    do_reset();
    load_image();
    feed_sigs();
    run_restore(1'b0, 'h30, inj, rc);
    chk("mid_injects", inj, 'h30);
    idle_bus();
    step();
    chk("mid_inject_pending", 32'(out_nCS), 0);
    chk("mid_inject_addr", 32'(out_addr), 32'h680);
    reset_n  = 1'b0;
    mon_addr = 11'h5aa;
    #1;
    chk_pass("mid_rst_passthru");
    chk("mid_rst_restoring", 32'(restoring), 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_armed", 32'(armed), 0);
    for (int i = 0; i < 4; i++) game_write(sig_addr[i], sig_data[i]);
    step();
    step();
    chk("partial_sigs_armed", 32'(armed), 0);
    game_write(sig_addr[4], sig_data[4]);
    step();
    chk("resigned_armed", 32'(armed), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("unloaded_restoring", 32'(restoring), 0);
      chk_pass("unloaded_passthru");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
